// File: rtl/updown_ctrl_pkg.sv
// Shared constants for the updown_ctrl run-to-target counter controller.
package updown_ctrl_pkg;

  localparam int WIDTH_DEF    = 4;
  localparam int DIV_BITS_DEF = 25;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic logic [1:0] onehot2(input logic idx);
    onehot2 = idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/updown_ctrl_tick_gen.sv
// Step-rate prescaler: one-cycle tick every 2^DIV_BITS clk cycles, restartable via clr.
module updown_tick_gen
  import updown_ctrl_pkg::*;
#(
  parameter int DIV_BITS = DIV_BITS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  logic [DIV_BITS-1:0] pre_q;
  logic [DIV_BITS-1:0] pre_d;

  // Next prescaler value: restart on clear, otherwise free-run.
  always_comb begin
    if (clr) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + DIV_BITS'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign tick = &pre_q;

endmodule

// File: rtl/updown_ctrl.sv
// Round-robin, run-to-target up/down counter controller for two requesters.
// Build option: define UPDOWN_CTRL_WRAP_EN to let runs wrap modulo 2^WIDTH.
module updown_ctrl
  import updown_ctrl_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DIV_BITS = DIV_BITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       dir,
  input  logic [WIDTH-1:0] tgt0,
  input  logic [WIDTH-1:0] tgt1,
  output logic [1:0]       gnt,
  output logic             owner,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             err
);

  logic [1:0]       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             dir_q, dir_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             owner_q, owner_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             grant_s;
  logic             win_s;
  logic             tick_s;
  logic             blocked_s;
  logic [WIDTH-1:0] next_cnt_s;

  updown_tick_gen #(.DIV_BITS(DIV_BITS)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (grant_s),
    .tick (tick_s)
  );

  // Candidate next count and whether the step would cross a boundary.
  always_comb begin
    if (dir_q == DIR_UP) begin
      next_cnt_s = count_q + WIDTH'(1);
    end else begin
      next_cnt_s = count_q - WIDTH'(1);
    end
`ifdef UPDOWN_CTRL_WRAP_EN
    blocked_s = 1'b0;
`else
    if (dir_q == DIR_UP) begin
      blocked_s = (count_q == '1);
    end else begin
      blocked_s = (count_q == '0);
    end
`endif
  end

  // Arbiter, FSM and counter next-state logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    tgt_d   = tgt_q;
    dir_d   = dir_q;
    owner_d = owner_q;
    err_d   = err_q;
    gnt_d   = 2'b00;
    grant_s = 1'b0;
    win_s   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          win_s   = req[ptr_q] ? ptr_q : ~ptr_q;
          grant_s = 1'b1;
          gnt_d   = onehot2(win_s);
          owner_d = win_s;
          ptr_d   = ~win_s;
          dir_d   = dir[win_s];
          tgt_d   = win_s ? tgt1 : tgt0;
          err_d   = 1'b0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // The first RUN cycle resolves zero-length runs before any tick can occur.
        if (count_q == tgt_q) begin
          state_d = ST_DONE;
        end else if (tick_s) begin
          if (blocked_s) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            count_d = next_cnt_s;
            state_d = (next_cnt_s == tgt_q) ? ST_DONE : ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      count_q <= '0;
      tgt_q   <= '0;
      dir_q   <= DIR_DOWN;
      gnt_q   <= 2'b00;
      owner_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      tgt_q   <= tgt_d;
      dir_q   <= dir_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign count = count_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_updown_ctrl.sv
// Randomized self-checking bench for updown_ctrl (WIDTH=4, DIV_BITS=2).
module tb_updown_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] dir;
  logic [3:0] tgt0;
  logic [3:0] tgt1;
  logic [1:0] gnt;
  logic       owner;
  logic       busy;
  logic [3:0] count;
  logic       done;
  logic       err;

  int tests_run    = 0;
  int tests_failed = 0;

  // Transaction-level model state
  logic [3:0] m_count;
  logic       m_ptr;

  updown_ctrl #(.WIDTH(4), .DIV_BITS(2)) dut (
    .clk(clk), .rst(rst), .req(req), .dir(dir), .tgt0(tgt0), .tgt1(tgt1),
    .gnt(gnt), .owner(owner), .busy(busy), .count(count), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Run plan from start/direction/target: real steps m, done offset d (cycles after gnt), error flag e
  function automatic void plan(input logic [3:0] s, input logic up, input logic [3:0] t,
                               output int m, output int d, output logic e);
`ifdef UPDOWN_CTRL_WRAP_EN
    m = up ? int'(4'(t - s)) : int'(4'(s - t));
    e = 1'b0;
`else
    if (up) begin
      if (t >= s) begin m = int'(t) - int'(s); e = 1'b0; end
      else begin m = 15 - int'(s); e = 1'b1; end
    end else begin
      if (t <= s) begin m = int'(s) - int'(t); e = 1'b0; end
      else begin m = int'(s); e = 1'b1; end
    end
`endif
    if (e) d = 4 * (m + 1);
    else if (m == 0) d = 1;
    else d = 4 * m;
  endfunction

  task automatic test_run(input logic [1:0] mask, input logic [1:0] d_in,
                          input logic [3:0] t0, input logic [3:0] t1);
    int w, m, dd, waited, st;
    logic e, up;
    logic [3:0] s, tg, ec;
    logic [8:0] exp_v, act_v;
    req = mask; dir = d_in; tgt0 = t0; tgt1 = t1;
    if (mask == 2'b01) w = 0;
    else if (mask == 2'b10) w = 1;
    else w = int'(m_ptr);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (gnt === 2'b00 && waited < 10);
    tests_run++;
    if (waited !== 1) begin
      tests_failed++;
      $display("FAIL grant_latency: got %0d cycles, expected 1", waited);
    end
    tests_run++;
    if ({gnt, owner, busy, done, err} !== {2'b01 << w, w[0], 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL grant: gnt=%b owner=%b busy=%b done=%b err=%b, expected gnt=%b owner=%0d busy=1 done=0 err=0",
               gnt, owner, busy, done, err, 2'b01 << w, w);
    end
    req[w] = 1'b0;
    s  = m_count;
    up = d_in[w];
    tg = (w == 1) ? t1 : t0;
    plan(s, up, tg, m, dd, e);
    for (int t = 1; t <= dd + 1; t++) begin
      @(negedge clk);
      st = t / 4;
      if (st > m) st = m;
      ec = up ? s + 4'(st) : s - 4'(st);
      exp_v = {ec, 2'b00, (t == dd), (t <= dd), (e && t >= dd)};
      act_v = {count, gnt, done, busy, err};
      tests_run++;
      if (act_v !== exp_v) begin
        tests_failed++;
        $display("FAIL run_t%0d (s=%0d up=%b tgt=%0d): count=%0d gnt=%b done=%b busy=%b err=%b, expected count=%0d gnt=00 done=%b busy=%b err=%b",
                 t, s, up, tg, count, gnt, done, busy, err, ec, exp_v[2], exp_v[1], exp_v[0]);
      end
    end
    tests_run++;
    if (owner !== w[0]) begin
      tests_failed++;
      $display("FAIL owner_hold: got %b, expected %0d", owner, w);
    end
    m_count = up ? s + 4'(m) : s - 4'(m);
    m_ptr   = ~w[0];
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 2'b00; dir = 2'b00; tgt0 = 4'd0; tgt1 = 4'd0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({count, gnt, owner, busy, done, err} !== {4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset: count=%0d gnt=%b owner=%b busy=%b done=%b err=%b, expected all 0",
               count, gnt, owner, busy, done, err);
    end
    rst = 1'b0;
    m_count = 4'd0;
    m_ptr   = 1'b0;
  endtask

  task automatic test_single_up;
    test_run(2'b01, 2'b01, 4'd3, 4'd0);
  endtask

  task automatic test_reset_mid_run;
    int waited;
    req = 2'b01; dir = 2'b01; tgt0 = 4'd7; tgt1 = 4'd0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (gnt === 2'b00 && waited < 10);
    req = 2'b00;
    repeat (8) @(negedge clk);
    tests_run++;
    if (count !== m_count + 4'd2) begin
      tests_failed++;
      $display("FAIL midrun_count: got %0d, expected %0d", count, m_count + 4'd2);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests_run++;
      if ({count, gnt, owner, busy, done, err} !== 10'd0) begin
        tests_failed++;
        $display("FAIL midrun_reset%0d: count=%0d gnt=%b owner=%b busy=%b done=%b err=%b, expected all 0",
                 i, count, gnt, owner, busy, done, err);
      end
    end
    rst = 1'b0;
    m_count = 4'd0;
    m_ptr   = 1'b0;
  endtask

  task automatic test_round_robin;
    test_run(2'b11, 2'b11, 4'd3, 4'd6);
    test_run(2'b10, 2'b11, 4'd3, 4'd6);
    test_run(2'b11, 2'b00, 4'd4, 4'd9);
    test_run(2'b10, 2'b00, 4'd0, 4'd4);
  endtask

  task automatic test_boundary;
    test_run(2'b01, 2'b01, 4'd14, 4'd0);
    test_run(2'b10, 2'b10, 4'd0, 4'd2);
  endtask

  task automatic test_zero_length;
    logic d0;
    d0 = (m_count < 4'd5);
    test_run(2'b01, {1'b0, d0}, 4'd5, 4'd0);
    test_run(2'b01, 2'b00, 4'd5, 4'd0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 15; i++) begin
      test_run(2'($urandom_range(3, 1)), 2'($urandom_range(3, 0)),
               4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
    end
  endtask

  initial begin
    test_reset;
    test_single_up;
    test_reset_mid_run;
    test_round_robin;
    test_boundary;
    test_zero_length;
    test_random;
    req = 2'b00;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
